// File: rtl/poly_feeder_if.sv
// poly_feeder_if
//  Bundles the request, engine-pin and response signals of the polynomial
//  engine feeder.
//  master : the feeder itself (drives req_ready, go, data_out, rsp_*, busy)
//  slave  : the surrounding host/engine side (drives req_*, result_valid_in,
//           data_result_in, rsp_ready)
//  Ports  : parameter DATA_W sets operand/result width.
interface poly_feeder_if #(
  parameter int DATA_W = 8
);
  // host request
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic [DATA_W-1:0] req_c;
  logic [DATA_W-1:0] req_x;
  // engine pins
  logic              go;
  logic [DATA_W-1:0] data_out;
  logic              result_valid_in;
  logic [DATA_W-1:0] data_result_in;
  // host response
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_timeout;
  logic              busy;

  modport master (
    input  req_valid, req_a, req_b, req_c, req_x,
    output req_ready,
    output go, data_out,
    input  result_valid_in, data_result_in,
    output rsp_valid, rsp_data, rsp_timeout,
    input  rsp_ready,
    output busy
  );

  modport slave (
    output req_valid, req_a, req_b, req_c, req_x,
    input  req_ready,
    input  go, data_out,
    output result_valid_in, data_result_in,
    input  rsp_valid, rsp_data, rsp_timeout,
    output rsp_ready,
    input  busy
  );
endinterface

// File: rtl/poly_feeder.sv
// poly_feeder
//  Host-side initiator for the polynomial engine's press/release Go/DataIn
//  load protocol. Accepts one {A,B,C,X} request, presents each operand on
//  data_out with a setup phase (go=0) followed by a go-high phase, then waits
//  for the engine's result (or a timeout) and offers it on a valid/ready
//  response port.
//  Ports:
//   clk     rising-edge clock
//   resetn  synchronous active-low reset
//   bus     poly_feeder_if.master: req_* request, go/data_out engine pins,
//           result_valid_in/data_result_in engine result, rsp_* response,
//           busy (high whenever not idle)
//  Every output is a register or a pure decode of the state register.
module poly_feeder #(
  parameter int DATA_W      = 8,
  parameter int SETUP_CYC   = 1,
  parameter int GO_HIGH_CYC = 1,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic          clk,
  input  logic          resetn,
  poly_feeder_if.master bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_PULSE = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  // One shared counter times setup, go-high and wait phases; size it for the
  // longest of the three.
  localparam int MAX_A  = (SETUP_CYC > GO_HIGH_CYC) ? SETUP_CYC : GO_HIGH_CYC;
  localparam int MAX_C  = (MAX_A > TIMEOUT_CYC) ? MAX_A : TIMEOUT_CYC;
  localparam int CNT_W  = $clog2(MAX_C + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(GO_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [2:0]        state_reg, state_next;
  logic [1:0]        k_reg, k_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              go_reg, go_next;
  logic [DATA_W-1:0] data_out_reg, data_out_next;
  logic [DATA_W-1:0] rsp_data_reg, rsp_data_next;
  logic              rsp_timeout_reg, rsp_timeout_next;
  logic              load_ops;

  logic [DATA_W-1:0] req_operand [4];
  logic [DATA_W-1:0] operand_reg [4];
  logic [DATA_W-1:0] operand_sel;

  assign req_operand[0] = bus.req_a;
  assign req_operand[1] = bus.req_b;
  assign req_operand[2] = bus.req_c;
  assign req_operand[3] = bus.req_x;

  // Operands are captured on the accepting edge so the host may change req_*
  // immediately afterwards.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_operand
      always_ff @(posedge clk) begin
        if (!resetn) begin
          operand_reg[gi] <= '0;
        end else if (load_ops) begin
          operand_reg[gi] <= req_operand[gi];
        end
      end
    end
  endgenerate

  always_comb begin
    state_next       = state_reg;
    k_next           = k_reg;
    cnt_next         = cnt_reg;
    rsp_data_next    = rsp_data_reg;
    rsp_timeout_next = rsp_timeout_reg;
    load_ops         = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.req_valid) begin
          load_ops   = 1'b1;
          k_next     = 2'd0;
          cnt_next   = '0;
          state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_reg == SETUP_LAST) begin
          cnt_next   = '0;
          state_next = ST_PULSE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_PULSE: begin
        if (cnt_reg == PULSE_LAST) begin
          cnt_next = '0;
          if (k_reg == 2'd3) begin
            state_next = ST_WAIT;
          end else begin
            k_next     = k_reg + 2'd1;
            state_next = ST_SETUP;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_WAIT: begin
        // A result arriving on the timeout edge still counts as a result.
        if (bus.result_valid_in) begin
          rsp_data_next    = bus.data_result_in;
          rsp_timeout_next = 1'b0;
          cnt_next         = '0;
          state_next       = ST_RESP;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          rsp_data_next    = '0;
          rsp_timeout_next = 1'b1;
          cnt_next         = '0;
          state_next       = ST_RESP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
        k_next     = 2'd0;
      end
    endcase
  end

  // On the accepting edge the operand registers are not yet loaded, so the
  // first data_out value comes straight from the request.
  assign operand_sel = load_ops ? req_operand[k_next] : operand_reg[k_next];

  always_comb begin
    go_next       = (state_next == ST_PULSE);
    data_out_next = '0;
    if ((state_next == ST_SETUP) || (state_next == ST_PULSE)) begin
      data_out_next = operand_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg       <= ST_IDLE;
      k_reg           <= 2'd0;
      cnt_reg         <= '0;
      go_reg          <= 1'b0;
      data_out_reg    <= '0;
      rsp_data_reg    <= '0;
      rsp_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      k_reg           <= k_next;
      cnt_reg         <= cnt_next;
      go_reg          <= go_next;
      data_out_reg    <= data_out_next;
      rsp_data_reg    <= rsp_data_next;
      rsp_timeout_reg <= rsp_timeout_next;
    end
  end

  assign bus.req_ready   = (state_reg == ST_IDLE);
  assign bus.busy        = (state_reg != ST_IDLE);
  assign bus.rsp_valid   = (state_reg == ST_RESP);
  assign bus.go          = go_reg;
  assign bus.data_out    = data_out_reg;
  assign bus.rsp_data    = rsp_data_reg;
  assign bus.rsp_timeout = rsp_timeout_reg;

endmodule

// File: tb/tb_poly_feeder.sv
// tb_poly_feeder
//  Drives poly_feeder with directed and random requests, with a small
//  behavioural engine attached to the go/data_out pins.
module tb_poly_feeder;

  localparam int DATA_W      = 8;
  localparam int TIMEOUT_CYC = 16;
  localparam int LAT_NORMAL  = 14;
  localparam int LAT_TIMEOUT = 8 + TIMEOUT_CYC;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;
  int   go_rises = 0;
  logic go_prev = 1'b0;

  poly_feeder_if #(.DATA_W(DATA_W)) bus ();

  poly_feeder #(
    .DATA_W(DATA_W), .SETUP_CYC(1), .GO_HIGH_CYC(1), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] poly(input int a, input int b, input int c, input int x);
    int r;
    r = (a * x + b) * x + c;
    return 8'(r);
  endfunction

  // Behavioural engine: latches data_out on each rising go, raises
  // ResultValid in the 6th cycle after the 4th operand is latched.
  logic       eng_en;
  int         eng_idx;
  int         eng_delay;
  logic       eng_go_q;
  logic [7:0] eng_ops [4];
  logic       eng_rv;
  logic [7:0] eng_dr;

  always @(posedge clk) begin
    if (!resetn) begin
      eng_idx   <= 0;
      eng_delay <= 0;
      eng_go_q  <= 1'b0;
      eng_rv    <= 1'b0;
      eng_dr    <= 8'd0;
    end else begin
      eng_go_q <= bus.go;
      eng_rv   <= 1'b0;
      if (bus.go && !eng_go_q) begin
        eng_ops[eng_idx] <= bus.data_out;
        if (eng_idx == 3) begin
          eng_idx   <= 0;
          eng_delay <= 5;
        end else begin
          eng_idx <= eng_idx + 1;
        end
      end
      if (eng_delay > 0) begin
        eng_delay <= eng_delay - 1;
        if (eng_delay == 1) begin
          eng_rv <= eng_en;
          eng_dr <= poly(eng_ops[0], eng_ops[1], eng_ops[2], eng_ops[3]);
        end
      end
    end
  end

  assign bus.result_valid_in = eng_rv;
  assign bus.data_result_in  = eng_dr;

  always @(negedge clk) begin
    if (bus.go && !go_prev) go_rises = go_rises + 1;
    go_prev = bus.go;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction; called from a negedge with the feeder idle.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input logic [7:0] x, input int bp, input bit expect_to,
                      input string tag);
    int n;
    int g0;
    logic [7:0] exp_data;
    exp_data = expect_to ? 8'd0 : poly(a, b, c, x);
    @(negedge clk);
    check({tag, "_req_ready_idle"}, bus.req_ready, 1);
    bus.req_a = a; bus.req_b = b; bus.req_c = c; bus.req_x = x;
    bus.req_valid = 1'b1;
    bus.rsp_ready = (bp == 0);
    g0 = go_rises;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_a = 8'($urandom); bus.req_b = 8'($urandom);
    bus.req_c = 8'($urandom); bus.req_x = 8'($urandom);
    check({tag, "_busy"}, bus.busy, 1);
    check({tag, "_req_ready_busy"}, bus.req_ready, 0);
    n = 0;
    while (!bus.rsp_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rsp_valid"}, bus.rsp_valid, 1);
    check({tag, "_latency"}, n, expect_to ? LAT_TIMEOUT : LAT_NORMAL);
    check({tag, "_rsp_data"}, bus.rsp_data, exp_data);
    check({tag, "_rsp_timeout"}, bus.rsp_timeout, expect_to);
    for (int i = 0; i < bp; i++) begin
      check({tag, "_bp_valid"}, bus.rsp_valid, 1);
      check({tag, "_bp_data"}, bus.rsp_data, exp_data);
      check({tag, "_bp_req_ready"}, bus.req_ready, 0);
      check({tag, "_bp_go"}, bus.go, 0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check({tag, "_rsp_done"}, bus.rsp_valid, 0);
    check({tag, "_req_ready_after"}, bus.req_ready, 1);
    check({tag, "_go_pulses"}, go_rises - g0, 4);
    $display("txn %s a=%0d b=%0d c=%0d x=%0d rsp=%0d timeout=%0b latency=%0d",
             tag, a, b, c, x, bus.rsp_data, bus.rsp_timeout, n);
  endtask

  int         t5_ops [3][4];
  int         got_q [$];
  int         t5_idx;
  bit         accept;
  int         g0_t5;
  int         seen_rsp;

  task automatic drive_t5(input int i);
    bus.req_a = 8'(t5_ops[i][0]); bus.req_b = 8'(t5_ops[i][1]);
    bus.req_c = 8'(t5_ops[i][2]); bus.req_x = 8'(t5_ops[i][3]);
  endtask

  initial begin
    resetn = 1'b0;
    eng_en = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_a = 8'd0; bus.req_b = 8'd0; bus.req_c = 8'd0; bus.req_x = 8'd0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_go", bus.go, 0);
    check("rst_data_out", bus.data_out, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_timeout", bus.rsp_timeout, 0);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_busy", bus.busy, 0);
    resetn = 1'b1;

    // basic, wrap, backpressure
    send(8'd2, 8'd3, 8'd4, 8'd5, 0, 1'b0, "basic");
    send(8'd16, 8'd0, 8'd1, 8'd16, 0, 1'b0, "wrap16");
    send(8'd255, 8'd255, 8'd255, 8'd255, 0, 1'b0, "wrap255");
    send(8'd7, 8'd9, 8'd11, 8'd13, 5, 1'b0, "backpressure");

    // timeout with the engine silent
    eng_en = 1'b0;
    send(8'd1, 8'd2, 8'd3, 8'd4, 2, 1'b1, "timeout");
    eng_en = 1'b1;

    // random requests with random backpressure
    for (int r = 0; r < 6; r++) begin
      send(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
           int'($urandom_range(0, 3)), 1'b0, "random");
    end

    // back-to-back with req_valid held
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 4; j++) t5_ops[i][j] = int'($urandom_range(0, 255));
    got_q.delete();
    @(negedge clk);
    g0_t5 = go_rises;
    bus.rsp_ready = 1'b1;
    t5_idx = 0;
    drive_t5(0);
    bus.req_valid = 1'b1;
    for (int i = 0; i < 200 && got_q.size() < 3; i++) begin
      accept = bus.req_valid && bus.req_ready;
      if (bus.rsp_valid) got_q.push_back(int'(bus.rsp_data));
      @(negedge clk);
      if (accept) begin
        t5_idx++;
        if (t5_idx < 3) drive_t5(t5_idx);
        else bus.req_valid = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
    check("b2b_count", got_q.size(), 3);
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      check("b2b_data", got_q[i],
            poly(t5_ops[i][0], t5_ops[i][1], t5_ops[i][2], t5_ops[i][3]));
      $display("txn b2b%0d a=%0d b=%0d c=%0d x=%0d rsp=%0d", i, t5_ops[i][0],
               t5_ops[i][1], t5_ops[i][2], t5_ops[i][3], got_q[i]);
    end
    check("b2b_go_pulses", go_rises - g0_t5, 12);

    // reset during PULSE(2)
    @(negedge clk);
    bus.req_a = 8'd9; bus.req_b = 8'd8; bus.req_c = 8'd7; bus.req_x = 8'd6;
    bus.req_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("rstmid_pulse2_go", bus.go, 1);
    check("rstmid_pulse2_data", bus.data_out, 7);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("rstmid_go", bus.go, 0);
    check("rstmid_req_ready", bus.req_ready, 1);
    check("rstmid_rsp_valid", bus.rsp_valid, 0);
    seen_rsp = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.rsp_valid) seen_rsp++;
    end
    check("rstmid_no_rsp", seen_rsp, 0);
    $display("txn reset_mid_pulse2 aborted");
    send(8'd1, 8'd1, 8'd1, 8'd1, 0, 1'b0, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
